// File: rtl/seq_booth_divider_pkg.sv
// Shared types and constants for the sequential signed restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } divState_e;

    localparam int MAX_WIDTH = 32;

    // Quotient pattern reported for a zero divisor, sliced down to WIDTH by users.
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    function automatic int counterWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_booth_divider_if.sv
// Start/busy/ready handshake bundle between a requester and the divider.
interface seq_booth_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             ready;
    logic             div_zero;
    logic             ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, ready, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, ready, div_zero, ovf
    );
endinterface

// File: rtl/seq_booth_divider_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] partRem_i,
    input  logic           nextBit_i,
    input  logic [WIDTH:0] divMag_i,
    output logic [WIDTH:0] newRem_o,
    output logic           quotBit_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trialDiff;

    // One guard bit above the partial remainder makes the borrow visible as the sign.
    always_comb begin
        shifted   = {partRem_i, nextBit_i};
        trialDiff = shifted - {1'b0, divMag_i};
        quotBit_o = ~trialDiff[WIDTH+1];
        newRem_o  = quotBit_o ? trialDiff[WIDTH:0] : shifted[WIDTH:0];
    end
endmodule

// File: rtl/seq_booth_divider.sv
// Sequential signed divider: restoring division on magnitudes, then a sign-fix cycle.
module seq_booth_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    seq_booth_divider_if.slave bus
);
    localparam int               CNT_W    = counterWidth(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    divState_e        stateQ;
    logic [CNT_W-1:0] cntQ;
    logic [WIDTH:0]   remQ;
    logic [WIDTH:0]   divMagQ;
    logic [WIDTH-1:0] dvdShiftQ;
    logic [WIDTH-1:0] quotMagQ;
    logic             negQuotQ;
    logic             negRemQ;
    logic             dzPendQ;
    logic             ovfPendQ;
    logic [WIDTH-1:0] quotientQ;
    logic [WIDTH-1:0] remainderQ;
    logic             busyQ;
    logic             readyQ;
    logic             divZeroQ;
    logic             ovfQ;

    logic [WIDTH-1:0] dvdMagD;
    logic [WIDTH-1:0] dsrMagD;
    logic [WIDTH:0]   stepRemD;
    logic             stepBitD;

    // The most-negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign dvdMagD = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dsrMagD = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .partRem_i (remQ),
        .nextBit_i (dvdShiftQ[WIDTH-1]),
        .divMag_i  (divMagQ),
        .newRem_o  (stepRemD),
        .quotBit_o (stepBitD)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ     <= IDLE;
            cntQ       <= '0;
            remQ       <= '0;
            divMagQ    <= '0;
            dvdShiftQ  <= '0;
            quotMagQ   <= '0;
            negQuotQ   <= 1'b0;
            negRemQ    <= 1'b0;
            dzPendQ    <= 1'b0;
            ovfPendQ   <= 1'b0;
            quotientQ  <= '0;
            remainderQ <= '0;
            busyQ      <= 1'b0;
            readyQ     <= 1'b0;
            divZeroQ   <= 1'b0;
            ovfQ       <= 1'b0;
        end else begin
            readyQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (bus.start) begin
                        negQuotQ  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        negRemQ   <= bus.dividend[WIDTH-1];
                        dvdShiftQ <= dvdMagD;
                        divMagQ   <= {1'b0, dsrMagD};
                        quotMagQ  <= '0;
                        cntQ      <= '0;
                        divZeroQ  <= 1'b0;
                        ovfQ      <= 1'b0;
                        busyQ     <= 1'b1;
                        dzPendQ   <= (bus.divisor == '0);
                        ovfPendQ  <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                        // A zero divisor parks the raw dividend where the remainder is read from.
                        if (bus.divisor == '0) begin
                            remQ   <= {bus.dividend[WIDTH-1], bus.dividend};
                            stateQ <= FIX;
                        end else begin
                            remQ   <= '0;
                            stateQ <= CALC;
                        end
                    end
                end
                CALC: begin
                    remQ      <= stepRemD;
                    quotMagQ  <= {quotMagQ[WIDTH-2:0], stepBitD};
                    dvdShiftQ <= {dvdShiftQ[WIDTH-2:0], 1'b0};
                    cntQ      <= cntQ + CNT_W'(1);
                    if (cntQ == CNT_W'(WIDTH - 1)) begin
                        stateQ <= FIX;
                    end
                end
                FIX: begin
                    if (dzPendQ) begin
                        quotientQ  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        remainderQ <= remQ[WIDTH-1:0];
                    end else begin
                        quotientQ  <= negQuotQ ? -quotMagQ : quotMagQ;
                        remainderQ <= negRemQ ? -remQ[WIDTH-1:0] : remQ[WIDTH-1:0];
                    end
                    divZeroQ <= dzPendQ;
                    ovfQ     <= ovfPendQ;
                    readyQ   <= 1'b1;
                    busyQ    <= 1'b0;
                    stateQ   <= IDLE;
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign bus.quotient  = quotientQ;
    assign bus.remainder = remainderQ;
    assign bus.busy      = busyQ;
    assign bus.ready     = readyQ;
    assign bus.div_zero  = divZeroQ;
    assign bus.ovf       = ovfQ;
endmodule

// File: tb/tb_seq_booth_divider.sv
// Self-checking bench for seq_booth_divider: directed corner cases plus randomized operands.
module tb_seq_booth_divider;
    localparam int               W        = 8;
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;
    logic [W-1:0] lastQ;
    logic [W-1:0] lastR;

    seq_booth_divider_if #(.WIDTH(W)) busIf ();

    seq_booth_divider #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Signed division from plain integer arithmetic: truncation toward zero, remainder follows dividend.
    function automatic void referenceModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                           output logic [W-1:0] q, output logic [W-1:0] r,
                                           output logic dz, output logic ov);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = (sb == 0);
        ov = (sa == -(longint'(1) << (W - 1))) && (sb == -1);
        if (dz) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return MOST_NEG;
            1:       return '1;
            2:       return '0;
            3:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a negedge; launches one operation and waits (bounded) for its ready pulse.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int glitchEdge);
        logic [W-1:0] expQ;
        logic [W-1:0] expR;
        logic         expDz;
        logic         expOvf;
        int           edges;
        int           busyCycles;
        int           expLat;
        referenceModel(a, b, expQ, expR, expDz, expOvf);
        expLat = expDz ? 2 : W + 2;
        busIf.start    = 1'b1;
        busIf.dividend = a;
        busIf.divisor  = b;
        edges      = 0;
        busyCycles = 0;
        do begin
            @(negedge clk);
            edges++;
            busIf.start = 1'b0;
            if (glitchEdge > 0 && edges == glitchEdge + 1) begin
                busIf.start    = 1'b1;
                busIf.dividend = ~a;
                busIf.divisor  = b + W'(3);
            end
            if (busIf.busy) busyCycles++;
        end while (!busIf.ready && edges < 40);
        checkOutput("latency", 32'(edges), 32'(expLat));
        checkOutput("busyCycles", 32'(busyCycles), 32'(expLat - 1));
        checkOutput("ready", 32'(busIf.ready), 32'd1);
        checkOutput("quotient", 32'(busIf.quotient), 32'(expQ));
        checkOutput("remainder", 32'(busIf.remainder), 32'(expR));
        checkOutput("div_zero", 32'(busIf.div_zero), 32'(expDz));
        checkOutput("ovf", 32'(busIf.ovf), 32'(expOvf));
        lastQ = expQ;
        lastR = expR;
    endtask

    task automatic checkHold();
        @(negedge clk);
        checkOutput("readyOneCycle", 32'(busIf.ready), 32'd0);
        checkOutput("holdQuotient", 32'(busIf.quotient), 32'(lastQ));
        checkOutput("holdRemainder", 32'(busIf.remainder), 32'(lastR));
    endtask

    initial begin
        assertCount    = 0;
        failCount      = 0;
        lastQ          = '0;
        lastR          = '0;
        reset          = 1'b0;
        busIf.start    = 1'b0;
        busIf.dividend = '0;
        busIf.divisor  = '0;

        #1;
        checkOutput("rstQuotient", 32'(busIf.quotient), 32'd0);
        checkOutput("rstRemainder", 32'(busIf.remainder), 32'd0);
        checkOutput("rstBusy", 32'(busIf.busy), 32'd0);
        checkOutput("rstReady", 32'(busIf.ready), 32'd0);
        checkOutput("rstDivZero", 32'(busIf.div_zero), 32'd0);
        checkOutput("rstOvf", 32'(busIf.ovf), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] directed sign combinations");
        applyStimulus(W'(100), W'(7), 0);    checkHold();
        applyStimulus(W'(-100), W'(7), 0);   checkHold();
        applyStimulus(W'(100), W'(-7), 0);   checkHold();
        applyStimulus(W'(-100), W'(-7), 0);  checkHold();

        $display("[TB] overflow and divide by zero");
        applyStimulus(MOST_NEG, W'(-1), 0);  checkHold();
        applyStimulus(MOST_NEG, W'(1), 0);   checkHold();
        applyStimulus(W'(5), W'(0), 0);      checkHold();

        $display("[TB] start while busy, then back-to-back start in the ready cycle");
        applyStimulus(W'(100), W'(7), 3);
        applyStimulus(W'(9), W'(4), 0);      checkHold();

        $display("[TB] asynchronous reset mid-operation");
        busIf.start    = 1'b1;
        busIf.dividend = W'(100);
        busIf.divisor  = W'(7);
        @(negedge clk);
        busIf.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abortQuotient", 32'(busIf.quotient), 32'd0);
        checkOutput("abortRemainder", 32'(busIf.remainder), 32'd0);
        checkOutput("abortBusy", 32'(busIf.busy), 32'd0);
        checkOutput("abortReady", 32'(busIf.ready), 32'd0);
        checkOutput("abortDivZero", 32'(busIf.div_zero), 32'd0);
        checkOutput("abortOvf", 32'(busIf.ovf), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abortNoReady", 32'(busIf.ready), 32'd0);
        end
        reset = 1'b1;
        applyStimulus(W'(127), W'(127), 0);  checkHold();

        $display("[TB] randomized operands");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(pickOperand(), pickOperand(), 0);
            if ($urandom_range(0, 1) == 1) checkHold();
            else @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
